// File: rtl/hazard_control_unit_if.sv
// Hazard controller signal bundle: ID/EX hazard inputs and pipeline-register enables/flushes.
// The pipeline (master) drives the ID/EX hazard inputs; the controller (slave) drives the enables and flushes.
interface hazard_control_unit_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_IsMulDiv;
  logic        ID_ReadsHiLo;
  logic        ID_Jump;
  logic [4:0]  ID_EX_Rt;
  logic        ID_EX_MemRead;
  logic        EX_BranchTaken;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        MulDiv_Busy;
  logic [15:0] Stall_Count;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo, ID_Jump,
           ID_EX_Rt, ID_EX_MemRead, EX_BranchTaken,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDiv_Busy, Stall_Count
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo, ID_Jump,
           ID_EX_Rt, ID_EX_MemRead, EX_BranchTaken,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDiv_Busy, Stall_Count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, branch/jump squash, mult/div occupancy holds.
// Control outputs are combinational from inputs and md_cnt; md_cnt and Stall_Count are registered.
module hazard_control_unit #(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 3
) (
  input logic              clk,
  input logic              reset,
  hazard_control_unit_if.slave hz
);

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [15:0]      stall_count_q, stall_count_d;
  logic             muldiv_busy;
  logic             load_use;
  logic             md_stall;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic             md_issue;

  always_comb begin
    muldiv_busy = (md_cnt_q != '0);
    load_use    = hz.ID_EX_MemRead && (hz.ID_EX_Rt != 5'd0) &&
                  ((hz.ID_EX_Rt == hz.ID_Rs) || (hz.ID_UsesRt && (hz.ID_EX_Rt == hz.ID_Rt)));
    md_stall    = muldiv_busy && (hz.ID_IsMulDiv || hz.ID_ReadsHiLo);
  end

  // A taken branch outranks every stall: the ID instruction is wrong-path anyway.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (hz.EX_BranchTaken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (md_stall || load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (hz.ID_Jump) begin
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    md_issue      = hz.ID_IsMulDiv && !hz.EX_BranchTaken && !md_stall && !load_use;
    md_cnt_d      = md_cnt_q;
    stall_count_d = stall_count_q;
    if (md_issue) begin
      md_cnt_d = CNT_W'(MULDIV_LATENCY);
    end else if (muldiv_busy) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
    if (!pc_write && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Reset holds the front end frozen and the pipeline registers cleared.
  always_comb begin
    hz.PC_Write    = reset ? 1'b0 : pc_write;
    hz.IF_ID_Write = reset ? 1'b0 : if_id_write;
    hz.IF_ID_Flush = reset ? 1'b1 : if_id_flush;
    hz.ID_EX_Flush = reset ? 1'b1 : id_ex_flush;
    hz.MulDiv_Busy = reset ? 1'b0 : muldiv_busy;
    hz.Stall_Count = stall_count_q;
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; expected responses are queued per vector
// and checked by an independent monitor on the falling edge.
module tb_hazard_control_unit;
  logic clk;
  logic reset;

  hazard_control_unit_if hz ();

  hazard_control_unit #(.MULDIV_LATENCY(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  typedef struct {
    string       nm;
    logic [3:0]  ctrl;  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
    logic        busy;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_sc = 0;

  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] BR    = 4'b1111;
  localparam logic [3:0] JMP   = 4'b1110;
  localparam logic [3:0] RST   = 4'b0011;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset             = 1'b1;
    hz.ID_Rs          = '0;
    hz.ID_Rt          = '0;
    hz.ID_UsesRt      = 1'b0;
    hz.ID_IsMulDiv    = 1'b0;
    hz.ID_ReadsHiLo   = 1'b0;
    hz.ID_Jump        = 1'b0;
    hz.ID_EX_Rt       = '0;
    hz.ID_EX_MemRead  = 1'b0;
    hz.EX_BranchTaken = 1'b0;
  end

  // Drive one cycle's inputs just after the rising edge and queue the expected response.
  task automatic step(input string nm, input logic r,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                      input logic md, input logic hl, input logic j,
                      input logic [4:0] exrt, input logic mr, input logic br,
                      input logic [3:0] ctrl, input logic busy);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = r;
    hz.ID_Rs          = rs;
    hz.ID_Rt          = rt;
    hz.ID_UsesRt      = ur;
    hz.ID_IsMulDiv    = md;
    hz.ID_ReadsHiLo   = hl;
    hz.ID_Jump        = j;
    hz.ID_EX_Rt       = exrt;
    hz.ID_EX_MemRead  = mr;
    hz.EX_BranchTaken = br;
    if (r) exp_sc = 0;
    e.nm   = nm;
    e.ctrl = ctrl;
    e.busy = busy;
    e.sc   = 16'(exp_sc);
    exp_q.push_back(e);
    if (!r && !ctrl[3] && exp_sc < 65535) exp_sc = exp_sc + 1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] act;
      e   = exp_q.pop_front();
      act = {hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Flush};
      n_vec++;
      if (act !== e.ctrl || hz.MulDiv_Busy !== e.busy || hz.Stall_Count !== e.sc) begin
        n_miss++;
        $display("FAIL %s: got ctrl=%b busy=%b stall_cnt=%0d, want ctrl=%b busy=%b stall_cnt=%0d",
                 e.nm, act, hz.MulDiv_Busy, hz.Stall_Count, e.ctrl, e.busy, e.sc);
      end
    end
  end

  initial begin
    //     name            rst rs  rt  ur md hl j  exrt mr br  ctrl   busy
    step("reset_a",        1, 0,  0,  0, 0, 0, 0, 0,   0, 0,  RST,   0);
    step("reset_b",        1, 0,  0,  0, 0, 0, 0, 0,   0, 0,  RST,   0);
    step("idle",           0, 0,  0,  0, 0, 0, 0, 0,   0, 0,  NORM,  0);
    // load-use on Rs, then cleared after one bubble
    step("lu_rs",          0, 8,  0,  0, 0, 0, 0, 8,   1, 0,  STALL, 0);
    step("lu_clear",       0, 8,  0,  0, 0, 0, 0, 8,   0, 0,  NORM,  0);
    // $0 and unused Rt never stall; used Rt does
    step("lu_r0",          0, 0,  0,  1, 0, 0, 0, 0,   1, 0,  NORM,  0);
    step("lu_rt_unused",   0, 0,  9,  0, 0, 0, 0, 9,   1, 0,  NORM,  0);
    step("lu_rt_used",     0, 0,  9,  1, 0, 0, 0, 9,   1, 0,  STALL, 0);
    step("lu_nomatch",     0, 3,  4,  1, 0, 0, 0, 9,   1, 0,  NORM,  0);
    // mult then mfhi: four stall cycles, mfhi issues when counter reaches zero
    step("mult_issue",     0, 0,  0,  0, 1, 0, 0, 0,   0, 0,  NORM,  0);
    for (int i = 0; i < 4; i++)
      step("mfhi_stall",   0, 0,  0,  0, 0, 1, 0, 0,   0, 0,  STALL, 1);
    step("mfhi_issue",     0, 0,  0,  0, 0, 1, 0, 0,   0, 0,  NORM,  0);
    // back-to-back mult, then occupancy drains with no dependent instruction
    step("mult2_issue",    0, 0,  0,  0, 1, 0, 0, 0,   0, 0,  NORM,  0);
    for (int i = 0; i < 4; i++)
      step("mult_b2b_stall", 0, 0, 0, 0, 1, 0, 0, 0,   0, 0,  STALL, 1);
    step("mult3_issue",    0, 0,  0,  0, 1, 0, 0, 0,   0, 0,  NORM,  0);
    for (int i = 0; i < 4; i++)
      step("md_drain",     0, 0,  0,  0, 0, 0, 0, 0,   0, 0,  NORM,  1);
    step("md_idle",        0, 0,  0,  0, 0, 0, 0, 0,   0, 0,  NORM,  0);
    // taken branch overrides load-use and squashes the mult
    step("br_override",    0, 8,  0,  0, 1, 0, 0, 8,   1, 1,  BR,    0);
    step("br_no_md_load",  0, 0,  0,  0, 0, 0, 0, 0,   0, 0,  NORM,  0);
    // jump held by load-use, flushes IF/ID once unstalled
    step("jmp_stalled",    0, 8,  0,  0, 0, 0, 1, 8,   1, 0,  STALL, 0);
    step("jmp_release",    0, 8,  0,  0, 0, 0, 1, 8,   0, 0,  JMP,   0);
    // reset mid-mult with md_cnt=3
    step("mult_issue4",    0, 0,  0,  0, 1, 0, 0, 0,   0, 0,  NORM,  0);
    step("md_cnt4",        0, 0,  0,  0, 0, 0, 0, 0,   0, 0,  NORM,  1);
    step("reset_mid_mult", 1, 0,  0,  0, 0, 0, 0, 0,   0, 0,  RST,   0);
    step("after_reset",    0, 0,  0,  0, 0, 0, 0, 0,   0, 0,  NORM,  0);
    // long load-use hold to saturate the stall counter
    step("sat_start",      0, 8,  0,  0, 0, 0, 0, 8,   1, 0,  STALL, 0);
    repeat (70000) @(posedge clk);
    exp_sc = (exp_sc + 70000 > 65535) ? 65535 : exp_sc + 70000;
    step("sat_hold",       0, 8,  0,  0, 0, 0, 0, 8,   1, 0,  STALL, 0);
    step("sat_hold2",      0, 8,  0,  0, 0, 0, 0, 8,   1, 0,  STALL, 0);
    step("sat_release",    0, 8,  0,  0, 0, 0, 0, 8,   0, 0,  NORM,  0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
